// File: rtl/spike_packet_scheduler.sv
// Spike-to-packet sequencer: walks the connection-pointer and downstream tables
// for every set bit of a latched spike vector and streams {src, dst} packets.
module spike_packet_scheduler #(
  parameter int NUM_NEURONS = 10,
  parameter int ADDR_W      = 12,
  parameter int PTR_W       = 5,
  parameter int MAX_CONN    = 30
) (
  input  logic                   CLK,
  input  logic                   RESETN,
  input  logic                   cfg_we,
  input  logic [1:0]             cfg_sel,
  input  logic [PTR_W-1:0]       cfg_idx,
  input  logic [ADDR_W-1:0]      cfg_data,
  input  logic                   spikes_valid,
  input  logic [NUM_NEURONS-1:0] spikes,
  output logic                   spikes_ready,
  output logic                   packet_valid,
  input  logic                   packet_ready,
  output logic [2*ADDR_W-1:0]    packet,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            pkt_count,
  output logic                   cfg_err
);

  localparam int NW = $clog2(NUM_NEURONS + 1);
  localparam int CW = $clog2(MAX_CONN);
  localparam logic [PTR_W-1:0] NN_P   = PTR_W'(NUM_NEURONS);
  localparam logic [PTR_W-1:0] MAXC_P = PTR_W'(MAX_CONN);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_e;

  logic [ADDR_W-1:0] addr_tbl [NUM_NEURONS];
  logic [PTR_W-1:0]  ptr_tbl  [NUM_NEURONS+1];
  logic [ADDR_W-1:0] conn_tbl [MAX_CONN];

  state_e                 state_q, state_d;
  logic [NUM_NEURONS-1:0] spike_q, spike_d;
  logic [NW-1:0]          n_q, n_d;
  logic [PTR_W-1:0]       j_q, j_d;
  logic [PTR_W-1:0]       end_q, end_d;
  logic [2*ADDR_W-1:0]    packet_q, packet_d;
  logic                   packet_valid_q, packet_valid_d;
  logic [15:0]            pkt_count_q, pkt_count_d;
  logic                   done_q, done_d;
  logic                   cfg_err_q, cfg_err_d;
  logic                   spikes_ready_q, spikes_ready_d;

  logic                   found_s;
  logic [NW-1:0]          n_s, n1_s;
  logic [PTR_W-1:0]       ptr_lo_s, ptr_hi_s, end_s, j_nxt_s;
  logic                   in_range_s, write_ok_s;

  // Lowest set spike bit and the clamped fan-out window of that neuron
  always_comb begin
    found_s = 1'b0;
    n_s     = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      found_s = found_s | spike_q[i];
      n_s     = spike_q[i] ? NW'(i) : n_s;
    end
    n1_s     = n_s + NW'(1);
    ptr_lo_s = ptr_tbl[n_s];
    ptr_hi_s = ptr_tbl[n1_s];
    end_s    = (ptr_hi_s > MAXC_P) ? MAXC_P : ptr_hi_s;
    j_nxt_s  = j_q + PTR_W'(1);
  end

  // Config index range check; writes only land while idle
  always_comb begin
    case (cfg_sel)
      2'd0:    in_range_s = (cfg_idx < NN_P);
      2'd1:    in_range_s = (cfg_idx <= NN_P);
      2'd2:    in_range_s = (cfg_idx < MAXC_P);
      default: in_range_s = 1'b0;
    endcase
    write_ok_s = cfg_we && (state_q == IDLE) && in_range_s;
    cfg_err_d  = cfg_err_q |
                 (cfg_we && ((state_q != IDLE) || ((cfg_sel != 2'd3) && !in_range_s)));
  end

  // Table storage is deliberately left unreset so a reset keeps the mapping
  always_ff @(posedge CLK) begin
    if (write_ok_s) begin
      case (cfg_sel)
        2'd0:    addr_tbl[cfg_idx[NW-1:0]] <= cfg_data;
        2'd1:    ptr_tbl[cfg_idx[NW-1:0]]  <= cfg_data[PTR_W-1:0];
        2'd2:    conn_tbl[cfg_idx[CW-1:0]] <= cfg_data;
        default: ;
      endcase
    end
  end

  // Sequencer next state; packet is loaded one edge ahead so EMIT streams back-to-back
  always_comb begin
    state_d        = state_q;
    spike_d        = spike_q;
    n_d            = n_q;
    j_d            = j_q;
    end_d          = end_q;
    packet_d       = packet_q;
    packet_valid_d = packet_valid_q;
    pkt_count_d    = pkt_count_q;
    done_d         = 1'b0;
    case (state_q)
      IDLE: begin
        if (spikes_valid && spikes_ready_q) begin
          spike_d     = spikes;
          pkt_count_d = 16'd0;
          state_d     = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (!found_s) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else if (ptr_lo_s >= end_s) begin
          spike_d[n_s] = 1'b0;
        end else begin
          n_d            = n_s;
          j_d            = ptr_lo_s;
          end_d          = end_s;
          packet_d       = {addr_tbl[n_s], conn_tbl[ptr_lo_s[CW-1:0]]};
          packet_valid_d = 1'b1;
          state_d        = EMIT;
        end
      end
      EMIT: begin
        if (packet_ready) begin
          pkt_count_d = (pkt_count_q == 16'hFFFF) ? pkt_count_q : pkt_count_q + 16'd1;
          if (j_nxt_s == end_q) begin
            spike_d[n_q]   = 1'b0;
            packet_valid_d = 1'b0;
            state_d        = SCAN;
          end else begin
            j_d      = j_nxt_s;
            packet_d = {addr_tbl[n_q], conn_tbl[j_nxt_s[CW-1:0]]};
          end
        end else begin
          packet_valid_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    spikes_ready_d = (state_d == IDLE);
  end

  // Control and output registers
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q        <= IDLE;
      spike_q        <= '0;
      n_q            <= '0;
      j_q            <= '0;
      end_q          <= '0;
      packet_q       <= '0;
      packet_valid_q <= 1'b0;
      pkt_count_q    <= 16'd0;
      done_q         <= 1'b0;
      cfg_err_q      <= 1'b0;
      spikes_ready_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      spike_q        <= spike_d;
      n_q            <= n_d;
      j_q            <= j_d;
      end_q          <= end_d;
      packet_q       <= packet_d;
      packet_valid_q <= packet_valid_d;
      pkt_count_q    <= pkt_count_d;
      done_q         <= done_d;
      cfg_err_q      <= cfg_err_d;
      spikes_ready_q <= spikes_ready_d;
    end
  end

  assign spikes_ready = spikes_ready_q;
  assign packet_valid = packet_valid_q;
  assign packet       = packet_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign pkt_count    = pkt_count_q;
  assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_spike_packet_scheduler.sv
// Scoreboard bench for spike_packet_scheduler: a table model predicts the packet
// stream for each spike vector, packets are popped and compared on handshake.
module tb_spike_packet_scheduler;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_sel = 2'd0;
  logic [4:0]  cfg_idx = 5'd0;
  logic [11:0] cfg_data = 12'd0;
  logic        spikes_valid = 1'b0;
  logic [9:0]  spikes = 10'd0;
  logic        spikes_ready;
  logic        packet_valid;
  logic        packet_ready = 1'b1;
  logic [23:0] packet;
  logic        busy;
  logic        done;
  logic [15:0] pkt_count;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;

  logic [11:0] m_addr [10];
  int          m_ptr  [11];
  logic [11:0] m_conn [30];
  logic [23:0] q [$];

  spike_packet_scheduler dut (
    .CLK(CLK), .RESETN(RESETN), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx),
    .cfg_data(cfg_data), .spikes_valid(spikes_valid), .spikes(spikes),
    .spikes_ready(spikes_ready), .packet_valid(packet_valid), .packet_ready(packet_ready),
    .packet(packet), .busy(busy), .done(done), .pkt_count(pkt_count), .cfg_err(cfg_err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input int idx, input logic [11:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_idx = 5'(idx); cfg_data = data;
    tick();
    cfg_we = 1'b0;
    if (sel == 2'd0 && idx < 10) m_addr[idx] = data;
    if (sel == 2'd1 && idx <= 10) m_ptr[idx] = int'(data[4:0]);
    if (sel == 2'd2 && idx < 30) m_conn[idx] = data;
  endtask

  task automatic start_vec(input logic [9:0] vec, output int n_exp);
    int hi;
    for (int n = 0; n < 10; n++) begin
      if (vec[n]) begin
        hi = (m_ptr[n+1] > 30) ? 30 : m_ptr[n+1];
        for (int j = m_ptr[n]; j < hi; j++) q.push_back({m_addr[n], m_conn[j]});
      end
    end
    n_exp = q.size();
    checks++;
    if (spikes_ready !== 1'b1) begin
      errors++; $display("FAIL accept_ready: spikes_ready=%b expected 1", spikes_ready);
    end
    spikes = vec; spikes_valid = 1'b1;
    tick();
    spikes_valid = 1'b0; spikes = 10'd0;
  endtask

  task automatic drain(input int stall, input int exp_cnt, input string name,
                       output int first_v, output int done_c, output int hs0, output int hs1);
    int c = 0; int stall_left = 0; int nhs = 0;
    logic [23:0] held = '0; logic [23:0] exp;
    first_v = -1; done_c = -1; hs0 = -1; hs1 = -1;
    while (done_c < 0 && c < 400) begin
      if (stall_left > 0) begin
        checks++;
        if (packet_valid !== 1'b1 || packet !== held) begin
          errors++;
          $display("FAIL %s stall_hold: valid=%b packet=%h expected valid=1 packet=%h",
                   name, packet_valid, packet, held);
        end
        packet_ready = 1'b0; stall_left--;
      end else if (stall != 0 && packet_valid && first_v < 0) begin
        held = packet; stall_left = 3; packet_ready = 1'b0;
      end else begin
        packet_ready = 1'b1;
      end
      if (packet_valid && first_v < 0) first_v = c;
      if (done === 1'b1) done_c = c;
      if (packet_valid && packet_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL %s extra_packet: got %h expected none", name, packet);
        end else begin
          exp = q.pop_front();
          if (packet !== exp) begin
            errors++; $display("FAIL %s packet: got %h expected %h", name, packet, exp);
          end
        end
        nhs++;
        if (nhs == 1) hs0 = c;
        if (nhs == 2) hs1 = c;
      end
      if (done_c < 0) begin tick(); c++; end
    end
    packet_ready = 1'b1;
    checks++;
    if (done_c < 0) begin errors++; $display("FAIL %s timeout: no done within %0d cycles", name, c); end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL %s missing: %0d packets expected but not sent", name, q.size()); end
    q.delete();
    checks++;
    if (pkt_count !== 16'(exp_cnt)) begin
      errors++; $display("FAIL %s pkt_count: got %0d expected %0d", name, pkt_count, exp_cnt);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || spikes_ready !== 1'b1) begin
      errors++; $display("FAIL %s after_done: done=%b busy=%b ready=%b expected 0 0 1",
                         name, done, busy, spikes_ready);
    end
  endtask

  task automatic test_reset();
    RESETN = 1'b0;
    tick(); tick();
    checks++;
    if (packet_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pkt_count !== 16'd0 ||
        cfg_err !== 1'b0 || packet !== 24'd0 || spikes_ready !== 1'b0) begin
      errors++; $display("FAIL reset_values: valid=%b busy=%b done=%b cnt=%0d err=%b pkt=%h rdy=%b expected all 0",
                         packet_valid, busy, done, pkt_count, cfg_err, packet, spikes_ready);
    end
    @(negedge CLK); RESETN = 1'b1;
    tick();
    checks++;
    if (spikes_ready !== 1'b1) begin errors++; $display("FAIL reset_release: spikes_ready=%b expected 1", spikes_ready); end
  endtask

  task automatic load_tables();
    int ptrs [11] = '{0, 2, 2, 5, 7, 3, 28, 28, 28, 28, 31};
    for (int i = 0; i < 10; i++) cfg_write(2'd0, i, 12'h001 + 12'(i));
    for (int i = 0; i < 11; i++) cfg_write(2'd1, i, 12'(ptrs[i]));
    for (int i = 0; i < 30; i++) cfg_write(2'd2, i, 12'h0A0 + 12'(i));
    cfg_write(2'd3, 0, 12'hFFF);
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_valid: cfg_err=%b expected 0", cfg_err); end
  endtask

  task automatic test_single();
    int n, fv, dc, h0, h1;
    start_vec(10'b0000000001, n);
    drain(0, 2, "single", fv, dc, h0, h1);
    checks++;
    if (fv != 1) begin errors++; $display("FAIL single_latency: first valid at %0d expected 1", fv); end
    checks++;
    if (h1 - h0 != 1) begin errors++; $display("FAIL single_b2b: handshake gap %0d expected 1", h1 - h0); end
  endtask

  task automatic test_multi();
    int n, fv, dc, h0, h1;
    start_vec(10'b0000000111, n);
    drain(0, 5, "multi", fv, dc, h0, h1);
  endtask

  task automatic test_stall();
    int n, fv, dc, h0, h1;
    start_vec(10'b0000000111, n);
    drain(1, 5, "stall", fv, dc, h0, h1);
  endtask

  task automatic test_empty();
    int n, fv, dc, h0, h1;
    start_vec(10'b0000000000, n);
    drain(0, 0, "empty", fv, dc, h0, h1);
    checks++;
    if (dc != 1 || fv != -1) begin
      errors++; $display("FAIL empty_done: done at %0d first valid %0d expected 1 and none", dc, fv);
    end
  endtask

  task automatic test_boundary();
    int n, fv, dc, h0, h1;
    start_vec(10'b1000011000, n);
    drain(0, 4, "boundary", fv, dc, h0, h1);
  endtask

  task automatic test_cfg_range();
    int n, fv, dc, h0, h1;
    cfg_write(2'd1, 11, 12'd0);
    checks++;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_range: cfg_err=%b expected 1", cfg_err); end
    cfg_write(2'd0, 10, 12'hBAD);
    start_vec(10'b0000000001, n);
    drain(0, 2, "range_tables", fv, dc, h0, h1);
  endtask

  task automatic test_reset_mid_emit();
    int n, fv, dc, h0, h1;
    start_vec(10'b0000000001, n);
    packet_ready = 1'b0;
    tick();
    checks++;
    if (packet_valid !== 1'b1) begin errors++; $display("FAIL midreset_emit: valid=%b expected 1", packet_valid); end
    RESETN = 1'b0;
    #1;
    checks++;
    if (packet_valid !== 1'b0 || busy !== 1'b0 || cfg_err !== 1'b0 || pkt_count !== 16'd0) begin
      errors++; $display("FAIL midreset_abort: valid=%b busy=%b err=%b cnt=%0d expected 0 0 0 0",
                         packet_valid, busy, cfg_err, pkt_count);
    end
    q.delete();
    tick();
    @(negedge CLK); RESETN = 1'b1; packet_ready = 1'b1;
    tick();
    checks++;
    if (spikes_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_release: ready=%b busy=%b expected 1 0", spikes_ready, busy);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (packet_valid !== 1'b0) begin errors++; $display("FAIL midreset_quiet: valid=%b expected 0", packet_valid); end
      tick();
    end
    start_vec(10'b0000000001, n);
    drain(0, 2, "after_reset", fv, dc, h0, h1);
  endtask

  task automatic test_cfg_busy();
    int n, fv, dc, h0, h1;
    start_vec(10'b0000000001, n);
    cfg_we = 1'b1; cfg_sel = 2'd2; cfg_idx = 5'd0; cfg_data = 12'hFFF;
    spikes_valid = 1'b1; spikes = 10'b0000000100;
    tick();
    cfg_we = 1'b0; spikes_valid = 1'b0; spikes = 10'd0;
    checks++;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_busy: cfg_err=%b expected 1", cfg_err); end
    drain(0, 2, "busy_drop", fv, dc, h0, h1);
    start_vec(10'b0000000001, n);
    drain(0, 2, "busy_tables", fv, dc, h0, h1);
  endtask

  initial begin
    test_reset();
    load_tables();
    test_single();
    test_multi();
    test_stall();
    test_empty();
    test_boundary();
    test_cfg_range();
    test_reset_mid_emit();
    test_cfg_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
